// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the arbiter FSM encoding.
// Opcodes are {instr[30], funct3}.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/Alu.sv
// RV32I integer ALU, purely combinational.
// Unlisted opcodes fall back to A+B.
module Alu #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [3:0]        op_i,
    output logic [DATA_W-1:0] result_o
);
    import alu_pkg::*;

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] shamt;
    assign shamt = b_i[SH_W-1:0];

    always_comb begin
        result_o = a_i + b_i;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SLT:  result_o = {{(DATA_W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {{(DATA_W-1){1'b0}}, a_i < b_i};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = a_i + b_i;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two valid/ready requesters; one operation in flight.
//   S_IDLE | waiting for a request, grant is combinational
//   S_EXEC | ALU evaluates the latched operands, result registered
//   S_RESP | result offered to the owner until it accepts
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter bit FAIR   = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [OP_W-1:0]   req_op0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [OP_W-1:0]   req_op1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);
    import alu_pkg::*;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] alu_y;
    logic              grant;

    Alu #(.DATA_W(DATA_W)) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (alu_y)
    );

    // On a tie, round-robin picks the port that was not served last.
    always_comb begin
        grant = 1'b0;
        case (req_valid)
            2'b10:   grant = 1'b1;
            2'b11:   grant = FAIR ? ~last_grant_q : 1'b0;
            default: grant = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        result_d     = result_q;
        count_d      = count_q;
        req_ready    = 2'b00;
        rsp_valid    = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    req_ready = grant ? 2'b10 : 2'b01;
                end
                if (|(req_valid & req_ready)) begin
                    a_d     = grant ? req_a1  : req_a0;
                    b_d     = grant ? req_b1  : req_b0;
                    op_d    = grant ? req_op1 : req_op0;
                    owner_d = grant;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = alu_y;
                state_d  = S_RESP;
            end
            S_RESP: begin
                rsp_valid = owner_q ? 2'b10 : 2'b01;
                if (rsp_ready[owner_q]) begin
                    last_grant_d = owner_q;
                    count_d      = count_q + CNT_W'(1);
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            result_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            result_q     <= result_d;
            count_q      <= count_d;
        end
    end

    assign rsp_result = result_q;
    assign busy       = (state_q != S_IDLE);
    assign op_count   = count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: u_rr is round-robin with a 16-bit counter,
// u_fp is fixed-priority with a 2-bit counter to exercise wrap.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  req_valid [2];
    logic [1:0]  req_ready [2];
    logic [1:0]  rsp_valid [2];
    logic [1:0]  rsp_ready [2];
    logic [31:0] a0 [2];
    logic [31:0] b0 [2];
    logic [31:0] a1 [2];
    logic [31:0] b1 [2];
    logic [3:0]  op0 [2];
    logic [3:0]  op1 [2];
    logic [31:0] rsp_result [2];
    logic        busy [2];
    logic [15:0] cnt_rr;
    logic [1:0]  cnt_fp;

    int n_chk = 0;
    int n_fail = 0;
    int exp_cnt [2];

    logic [3:0]  t_op [9] = '{ALU_SLL, ALU_SRL, ALU_XOR, ALU_OR, ALU_AND,
                              ALU_SLT, ALU_SLTU, 4'b1111, ALU_SRA};
    logic [31:0] t_a  [9] = '{32'h1, 32'h8000_0000, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
                              32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2,
                              32'h8000_0000};
    logic [31:0] t_b  [9] = '{32'h24, 32'h4, 32'hFF00_FF00, 32'hFF00_FF00,
                              32'hFF00_FF00, 32'h1, 32'h1, 32'h3, 32'h21};
    logic [31:0] t_y  [9] = '{32'h10, 32'h0800_0000, 32'h0FF0_0FF0, 32'hFFF0_FFF0,
                              32'hF000_F000, 32'h1, 32'h0, 32'h5, 32'hC000_0000};

    alu_share_arbiter #(.DATA_W(32), .OP_W(4), .FAIR(1'b1), .CNT_W(16)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_a0(a0[0]), .req_b0(b0[0]), .req_op0(op0[0]),
        .req_a1(a1[0]), .req_b1(b1[0]), .req_op1(op1[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_result(rsp_result[0]), .busy(busy[0]), .op_count(cnt_rr)
    );

    alu_share_arbiter #(.DATA_W(32), .OP_W(4), .FAIR(1'b0), .CNT_W(2)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_a0(a0[1]), .req_b0(b0[1]), .req_op0(op0[1]),
        .req_a1(a1[1]), .req_b1(b1[1]), .req_op1(op1[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_result(rsp_result[1]), .busy(busy[1]), .op_count(cnt_fp)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int p);
        return (p != 0) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [31:0] cnt_of(input int d);
        return (d == 0) ? {16'h0, cnt_rr} : {30'h0, cnt_fp};
    endfunction

    function automatic logic [31:0] cnt_exp(input int d);
        return (d == 0) ? (exp_cnt[0] & 32'hFFFF) : (exp_cnt[1] & 32'h3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int d, input int p, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            a0[d] = a; b0[d] = b; op0[d] = op;
        end else begin
            a1[d] = a; b1[d] = b; op1[d] = op;
        end
    endtask

    // Waits (bounded) for a grant, checks which port got it, then takes the accept edge.
    task automatic accept(input int d, input int p, input string tag);
        int n;
        n = 0;
        #1;
        while (req_ready[d] == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        check_eq(tag, {30'h0, req_ready[d]}, {30'h0, onehot(p)});
        tick();
        req_valid[d][p] = 1'b0;
    endtask

    task automatic serve(input int d, input int p, input logic [31:0] exp, input string tag);
        int n;
        n = 0;
        while (rsp_valid[d] == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, " vld"}, {30'h0, rsp_valid[d]}, {30'h0, onehot(p)});
        check_eq({tag, " res"}, rsp_result[d], exp);
        rsp_ready[d] = onehot(p);
        tick();
        rsp_ready[d] = 2'b00;
        exp_cnt[d]++;
        #1;
        check_eq({tag, " cnt"}, cnt_of(d), cnt_exp(d));
    endtask

    task automatic do_op(input int d, input int p, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
        set_ops(d, p, op, a, b);
        req_valid[d][p] = 1'b1;
        accept(d, p, {tag, " gnt"});
        serve(d, p, exp, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 2'b00; rsp_ready[d] = 2'b00;
            a0[d] = '0; b0[d] = '0; op0[d] = '0;
            a1[d] = '0; b1[d] = '0; op1[d] = '0;
            exp_cnt[d] = 0;
        end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq("rst req_ready", {30'h0, req_ready[d]}, 32'h0);
            check_eq("rst rsp_valid", {30'h0, rsp_valid[d]}, 32'h0);
            check_eq("rst result", rsp_result[d], 32'h0);
            check_eq("rst busy", {31'h0, busy[d]}, 32'h0);
            check_eq("rst count", cnt_of(d), 32'h0);
        end

        // Tie straight after reset: port 0 wins, port 1 holds and follows.
        set_ops(0, 0, ALU_SUB, 32'h3, 32'h5);
        set_ops(0, 1, ALU_SRA, 32'h8000_0000, 32'h4);
        req_valid[0] = 2'b11;
        accept(0, 0, "tie0 p0 gnt");
        serve(0, 0, 32'hFFFF_FFFE, "tie0 p0");
        accept(0, 1, "tie0 p1 gnt");
        serve(0, 1, 32'hF800_0000, "tie0 p1");

        // Exact latency: accept at N, valid at N+1, handshake at N+2.
        rsp_ready[0] = 2'b01;
        set_ops(0, 0, ALU_ADD, 32'd5, 32'd7);
        req_valid[0] = 2'b01;
        #1;
        check_eq("lat req_ready", {30'h0, req_ready[0]}, 32'h1);
        tick();
        req_valid[0] = 2'b00;
        #1;
        check_eq("lat exec busy", {31'h0, busy[0]}, 32'h1);
        check_eq("lat exec vld", {30'h0, rsp_valid[0]}, 32'h0);
        check_eq("lat exec rdy", {30'h0, req_ready[0]}, 32'h0);
        check_eq("lat exec cnt", cnt_of(0), cnt_exp(0));
        tick();
        check_eq("lat resp vld", {30'h0, rsp_valid[0]}, 32'h1);
        check_eq("lat resp res", rsp_result[0], 32'h0000_000C);
        tick();
        rsp_ready[0] = 2'b00;
        exp_cnt[0]++;
        #1;
        check_eq("lat done vld", {30'h0, rsp_valid[0]}, 32'h0);
        check_eq("lat done busy", {31'h0, busy[0]}, 32'h0);
        check_eq("lat done cnt", cnt_of(0), cnt_exp(0));

        // Port 0 was served last, so the next tie goes to port 1.
        set_ops(0, 0, ALU_SUB, 32'h3, 32'h5);
        set_ops(0, 1, ALU_SRA, 32'h8000_0000, 32'h4);
        req_valid[0] = 2'b11;
        accept(0, 1, "rr p1 gnt");
        serve(0, 1, 32'hF800_0000, "rr p1");
        accept(0, 0, "rr p0 gnt");
        serve(0, 0, 32'hFFFF_FFFE, "rr p0");

        for (int i = 0; i < 9; i++) begin
            do_op(0, i % 2, t_op[i], t_a[i], t_b[i], t_y[i], $sformatf("op%0d", i));
        end

        // Stalled response; port 1 request and non-owner rsp_ready are ignored.
        set_ops(0, 0, ALU_AND, 32'hDEAD_BEEF, 32'h0000_FFFF);
        req_valid[0] = 2'b01;
        accept(0, 0, "stall gnt");
        tick();
        set_ops(0, 1, ALU_ADD, 32'h1, 32'h1);
        req_valid[0] = 2'b10;
        rsp_ready[0] = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("stall vld", {30'h0, rsp_valid[0]}, 32'h1);
            check_eq("stall res", rsp_result[0], 32'h0000_BEEF);
            check_eq("stall rdy", {30'h0, req_ready[0]}, 32'h0);
            tick();
        end
        req_valid[0] = 2'b00;
        rsp_ready[0] = 2'b01;
        tick();
        rsp_ready[0] = 2'b00;
        exp_cnt[0]++;
        tick();
        tick();
        check_eq("lost req busy", {31'h0, busy[0]}, 32'h0);
        check_eq("lost req vld", {30'h0, rsp_valid[0]}, 32'h0);
        check_eq("lost req cnt", cnt_of(0), cnt_exp(0));

        // Reset while in EXEC drops the op and restores last_grant.
        set_ops(0, 0, ALU_ADD, 32'h1, 32'h2);
        req_valid[0] = 2'b01;
        accept(0, 0, "rst exec gnt");
        rst_n = 1'b0;
        tick();
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        check_eq("rst exec vld", {30'h0, rsp_valid[0]}, 32'h0);
        check_eq("rst exec busy", {31'h0, busy[0]}, 32'h0);
        check_eq("rst exec cnt", cnt_of(0), 32'h0);
        rst_n = 1'b1;
        tick();
        check_eq("rst no rsp", {30'h0, rsp_valid[0]}, 32'h0);
        set_ops(0, 0, ALU_ADD, 32'h10, 32'h20);
        set_ops(0, 1, ALU_XOR, 32'hFF, 32'h0F);
        req_valid[0] = 2'b11;
        accept(0, 0, "post rst p0 gnt");
        serve(0, 0, 32'h30, "post rst p0");
        accept(0, 1, "post rst p1 gnt");
        serve(0, 1, 32'hF0, "post rst p1");

        // Fixed priority: port 1 starves while port 0 keeps requesting; 2-bit count wraps.
        set_ops(1, 1, ALU_ADD, 32'd9, 32'd9);
        req_valid[1] = 2'b10;
        for (int i = 0; i < 10; i++) begin
            set_ops(1, 0, ALU_ADD, i, 32'd1);
            req_valid[1][0] = 1'b1;
            accept(1, 0, $sformatf("fp p0 gnt %0d", i));
            serve(1, 0, i + 1, $sformatf("fp p0 %0d", i));
        end
        accept(1, 1, "fp p1 gnt");
        serve(1, 1, 32'd18, "fp p1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
